// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side framing logic.
package uart_pkg;

    // Deframer states: hunt for SOF, take length, collect payload, check, drain.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Running XOR checksum step; stays 8 bits wide by construction.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Converts the receiver's level-style done signal into a one-cycle byte strobe.
// byte_data carries rx_byte during the strobe and holds the last byte afterwards.
module uart_byte_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done,
    input  logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic [7:0] byte_data
);

    logic       rx_done_q_r;
    logic [7:0] byte_hold_r;

    // Delay rx_done by one cycle; resets high so reset release never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q_r <= 1'b1;
        end else begin
            rx_done_q_r <= rx_done;
        end
    end

    // Keep a copy of the most recent received byte for consumers that look later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_hold_r <= 8'h00;
        end else if (byte_stb) begin
            byte_hold_r <= rx_byte;
        end else begin
            byte_hold_r <= byte_hold_r;
        end
    end

    assign byte_stb  = rx_done & ~rx_done_q_r;
    assign byte_data = byte_stb ? rx_byte : byte_hold_r;

endmodule

// File: rtl/uart_rx_deframer.sv
// Parses SOF/LEN/payload/XOR-checksum frames from the UART byte receiver,
// buffers the payload and replays it on a valid/ready byte stream.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done,
    input  logic [7:0] rx_byte,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
    localparam logic [AW-1:0] BUF_FIRST = AW'(0);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [GW-1:0] GAP_ZERO  = GW'(0);
    localparam logic [GW-1:0] GAP_MAX   = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    logic          byte_stb_s;
    logic [7:0]    rx_data_s;
    logic [GW-1:0] gap_inc_s;
    logic [IW-1:0] rd_next_s;

    state_t        state_r;
    logic [IW-1:0] len_r;
    logic [IW-1:0] wr_idx_r;
    logic [IW-1:0] rd_idx_r;
    logic [7:0]    chk_r;
    logic [GW-1:0] gap_r;
    logic [7:0]    buf_r [2**AW];

    uart_byte_strobe u_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .byte_stb  (byte_stb_s),
        .byte_data (rx_data_s)
    );

    // Saturating gap increment and next read index.
    always_comb begin
        gap_inc_s = gap_r;
        if (gap_r != GAP_MAX) begin
            gap_inc_s = gap_r + GAP_ONE;
        end else begin
            gap_inc_s = gap_r;
        end
        rd_next_s = rd_idx_r + IDX_ONE;
    end

    // Payload buffer write port; contents are left as-is when a frame is abandoned.
    always_ff @(posedge clk) begin
        if (state_r == PAYLOAD && byte_stb_s) begin
            buf_r[wr_idx_r[AW-1:0]] <= rx_data_s;
        end
    end

    // Frame parser, inter-byte timeout and output stream control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            len_r     <= IDX_ZERO;
            wr_idx_r  <= IDX_ZERO;
            rd_idx_r  <= IDX_ZERO;
            chk_r     <= 8'h00;
            gap_r     <= GAP_ZERO;
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            frame_ok  <= 1'b0;
            err_pulse <= 1'b0;
            case (state_r)
                IDLE: begin
                    gap_r <= GAP_ZERO;
                    if (byte_stb_s && rx_data_s == SOF_BYTE) begin
                        state_r <= LEN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LEN, PAYLOAD, CHK: begin
                    if (byte_stb_s) begin
                        // A byte on the expiry cycle takes priority over the timeout.
                        gap_r <= GAP_ZERO;
                        case (state_r)
                            LEN: begin
                                if (rx_data_s == 8'h00 || rx_data_s > MAX_LEN_B) begin
                                    err_pulse <= 1'b1;
                                    err_code  <= ERR_LEN;
                                    state_r   <= IDLE;
                                end else begin
                                    len_r    <= rx_data_s[IW-1:0];
                                    chk_r    <= rx_data_s;
                                    wr_idx_r <= IDX_ZERO;
                                    state_r  <= PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                chk_r    <= chk_update(chk_r, rx_data_s);
                                wr_idx_r <= wr_idx_r + IDX_ONE;
                                if (wr_idx_r == len_r - IDX_ONE) begin
                                    state_r <= CHK;
                                end else begin
                                    state_r <= PAYLOAD;
                                end
                            end
                            CHK: begin
                                if (rx_data_s == chk_r) begin
                                    frame_ok <= 1'b1;
                                    m_valid  <= 1'b1;
                                    m_data   <= buf_r[BUF_FIRST];
                                    m_last   <= (len_r == IDX_ONE);
                                    rd_idx_r <= IDX_ZERO;
                                    state_r  <= DRAIN;
                                end else begin
                                    err_pulse <= 1'b1;
                                    err_code  <= ERR_CHK;
                                    state_r   <= IDLE;
                                end
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end else if (gap_r == GAP_MAX) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        gap_r     <= GAP_ZERO;
                        state_r   <= IDLE;
                    end else begin
                        gap_r <= gap_inc_s;
                    end
                end
                DRAIN: begin
                    // Bytes arriving while draining are dropped; the drain is unaffected.
                    if (byte_stb_s) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_OVERRUN;
                    end
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            rd_idx_r <= rd_next_s;
                            m_data   <= buf_r[rd_next_s[AW-1:0]];
                            m_last   <= (rd_next_s == len_r - IDX_ONE);
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames push expected beats,
// errors and frame_ok pulses into queues; a monitor pops and compares.
module tb_uart_rx_deframer;

    localparam int TO = 64;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       rx_done = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       frame_ok;
    logic       err_pulse;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [1:0] err_q[$];
    int exp_frames = 0;
    logic [7:0] fb [0:31];

    uart_rx_deframer #(
        .MAX_LEN        (16),
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_ok  (frame_ok),
        .err_pulse (err_pulse),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Starts and ends on a rising edge; strobe cycle is idle+1 cycles after the start edge.
    task automatic send_byte(input logic [7:0] b, input int idle);
        #1 rx_done = 1'b0;
        repeat (idle) @(posedge clk);
        #1 rx_byte = b;
        rx_done = 1'b1;
        @(posedge clk);
    endtask

    task automatic send_frame(input int n, input bit good);
        if (good) begin
            for (int j = 2; j < n - 1; j++) exp_q.push_back({(j == n - 2), fb[j]});
            exp_frames++;
        end
        for (int i = 0; i < n; i++) send_byte(fb[i], 1);
        if (good) begin
            @(negedge clk);
            check("frame_ok_latency", 32'(frame_ok), 32'd1);
            check("valid_latency", 32'(m_valid), 32'd1);
            @(posedge clk);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && err_q.size() == 0 && !m_valid) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
        @(posedge clk);
    endtask

    // Monitor: stream beats, stall stability, error pulses and frame_ok pulses.
    initial begin
        logic       stall;
        logic [8:0] held;
        logic [8:0] e;
        stall = 1'b0;
        held  = 9'h000;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_hold", 32'({m_last, m_data}), 32'(held));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) unexpected("extra_beat", 32'({m_last, m_data}));
                    else begin
                        e = exp_q.pop_front();
                        check("beat", 32'({m_last, m_data}), 32'(e));
                    end
                end
                if (err_pulse) begin
                    if (err_q.size() == 0) unexpected("extra_err", 32'(err_code));
                    else check("err_code", 32'(err_code), 32'(err_q.pop_front()));
                end
                if (frame_ok) begin
                    if (exp_frames == 0) unexpected("extra_frame_ok", 32'(m_data));
                    else exp_frames--;
                end
                stall = m_valid && !m_ready;
                held  = {m_last, m_data};
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        logic [4:0] pat;
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // Basic frame, always ready.
        fb[0] = 8'hA5; fb[1] = 8'h03; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h33; fb[5] = 8'h03;
        send_frame(6, 1'b1);
        wait_idle();

        // Same frame, ready pattern 1-0-0-1-1 starting at the first valid cycle.
        pat = 5'b11001;
        m_ready = 1'b1;
        send_frame(6, 1'b1);
        for (int i = 1; i < 5; i++) begin
            if (i > 1) @(posedge clk);
            #1 m_ready = pat[i];
        end
        wait_idle();

        // Checksum mismatch (expected 0x32), then a good frame.
        fb[0] = 8'hA5; fb[1] = 8'h02; fb[2] = 8'h10; fb[3] = 8'h20; fb[4] = 8'h00;
        err_q.push_back(2'd1);
        send_frame(5, 1'b0);
        wait_idle();
        fb[4] = 8'h32;
        send_frame(5, 1'b1);
        wait_idle();

        // Length zero and length above maximum, then a one-byte frame.
        fb[0] = 8'hA5; fb[1] = 8'h00;
        err_q.push_back(2'd0);
        send_frame(2, 1'b0);
        fb[1] = 8'h11;
        err_q.push_back(2'd0);
        send_frame(2, 1'b0);
        fb[0] = 8'hA5; fb[1] = 8'h01; fb[2] = 8'h7E; fb[3] = 8'h7F;
        send_frame(4, 1'b1);
        wait_idle();

        // Maximum length frame: payload 0..15, checksum 0x10.
        fb[0] = 8'hA5; fb[1] = 8'h10;
        for (int i = 0; i < 16; i++) fb[2 + i] = 8'(i);
        fb[18] = 8'h10;
        send_frame(19, 1'b1);
        wait_idle();

        // Timeout: error registered exactly TO edges after the last strobe.
        fb[0] = 8'hA5; fb[1] = 8'h02; fb[2] = 8'h10;
        err_q.push_back(2'd2);
        send_frame(3, 1'b0);
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        check("timeout_early", 32'(err_pulse), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("timeout_pulse", 32'(err_pulse), 32'd1);
        check("timeout_code", 32'(err_code), 32'd2);
        @(posedge clk);
        wait_idle();

        // Byte strobe on the expiry cycle wins over the timeout.
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        exp_frames++;
        send_frame(3, 1'b0);
        send_byte(8'h20, TO - 1);
        send_byte(8'h32, 1);
        wait_idle();

        // Overrun while stalled in drain; payload must still come out intact.
        m_ready = 1'b0;
        fb[0] = 8'hA5; fb[1] = 8'h03; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h33; fb[5] = 8'h03;
        send_frame(6, 1'b1);
        err_q.push_back(2'd3);
        send_byte(8'h55, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("overrun_valid", 32'(m_valid), 32'd1);
        check("overrun_data", 32'(m_data), 32'h11);
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_idle();

        // Asynchronous reset mid-payload clears outputs at once.
        fb[0] = 8'hA5; fb[1] = 8'h03; fb[2] = 8'h11;
        send_frame(3, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_last", 32'(m_last), 32'd0);
        check("midrst_frame_ok", 32'(frame_ok), 32'd0);
        check("midrst_err_pulse", 32'(err_pulse), 32'd0);
        check("midrst_data", 32'(m_data), 32'd0);
        check("midrst_err_code", 32'(err_code), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        fb[0] = 8'hA5; fb[1] = 8'h01; fb[2] = 8'h7E; fb[3] = 8'h7F;
        send_frame(4, 1'b1);
        wait_idle();

        check("frames_left", 32'(exp_frames), 32'd0);
        check("beats_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
